// File: rtl/csa_resolve_pipe.sv
// Two-stage carry-save resolver: Sum + (Carry << 1) split at LO_W.
// The low slice is added in S1 and the high slice in S2, with valid/ready flow control.
module csa_resolve_pipe #(
  parameter int XLEN = 49,
  parameter int LO_W = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] Sum_i,
  input  logic [XLEN-1:0] Carry_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] Result_o,
  output logic            cout_o
);

  localparam int HI_W = XLEN - LO_W;

  logic            s1_v_q, s1_v_d;
  logic [LO_W-1:0] lo_q, lo_d;
  logic            lc_q, lc_d;
  logic [HI_W-1:0] shi_q, shi_d;
  logic [HI_W-1:0] chi_q, chi_d;

  logic            s2_v_q, s2_v_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            cout_q, cout_d;

  logic            adv2;
  logic            acc;
  logic [XLEN-1:0] c_sh;
  logic [LO_W:0]   lo_sum;
  logic [HI_W:0]   hi_sum;

  // Carry bit k has weight 2^(k+1); its top bit falls off the word.
  assign c_sh    = {Carry_i[XLEN-2:0], 1'b0};

  assign adv2    = !s2_v_q || ready_i;
  assign ready_o = !rst && (!s1_v_q || adv2);
  assign acc     = valid_i && ready_o;

  assign valid_o  = s2_v_q;
  assign Result_o = res_q;
  assign cout_o   = cout_q;

  always_comb begin
    lo_sum = {1'b0, Sum_i[LO_W-1:0]}
           + {1'b0, c_sh[LO_W-1:0]};
    hi_sum = {1'b0, shi_q}
           + {1'b0, chi_q}
           + {{HI_W{1'b0}}, lc_q};
  end

  always_comb begin
    s1_v_d = s1_v_q;
    lo_d   = lo_q;
    lc_d   = lc_q;
    shi_d  = shi_q;
    chi_d  = chi_q;
    s2_v_d = s2_v_q;
    res_d  = res_q;
    cout_d = cout_q;

    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d  = {hi_sum[HI_W-1:0], lo_q};
        cout_d = hi_sum[HI_W];
      end
    end

    // Drain and refill of S1 may coincide; the refill wins.
    if (acc) begin
      s1_v_d = 1'b1;
      lo_d   = lo_sum[LO_W-1:0];
      lc_d   = lo_sum[LO_W];
      shi_d  = Sum_i[XLEN-1:LO_W];
      chi_d  = c_sh[XLEN-1:LO_W];
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      lo_q   <= '0;
      lc_q   <= 1'b0;
      shi_q  <= '0;
      chi_q  <= '0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      lo_q   <= lo_d;
      lc_q   <= lc_d;
      shi_q  <= shi_d;
      chi_q  <= chi_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Directed and streaming checks for csa_resolve_pipe.
// Expected values come from hand tables and a full-width reference sum.
module tb_csa_resolve_pipe;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [48:0] Sum_i;
  logic [48:0] Carry_i;
  logic        valid_o;
  logic        ready_i;
  logic [48:0] Result_o;
  logic        cout_o;

  int tests;
  int fails;

  typedef struct {
    logic [48:0] s;
    logic [48:0] c;
    logic [48:0] r;
    logic        co;
    string       nm;
  } vec_t;

  vec_t tbl[9];

  logic [48:0] src_s[$];
  logic [48:0] src_c[$];
  logic [49:0] expq[$];

  csa_resolve_pipe #(.XLEN(49), .LO_W(25)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .Sum_i    (Sum_i),
    .Carry_i  (Carry_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .Result_o (Result_o),
    .cout_o   (cout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [49:0] model(input logic [48:0] s,
                                        input logic [48:0] c);
    model = {1'b0, s} + {1'b0, c[47:0], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic single(input vec_t v);
    valid_i = 1'b1;
    ready_i = 1'b1;
    Sum_i   = v.s;
    Carry_i = v.c;
    @(negedge clk);
    chk({v.nm, "_rdy"}, 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    Sum_i   = '0;
    Carry_i = '0;
    @(negedge clk);
    chk({v.nm, "_early"}, 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({v.nm, "_vld"}, 64'(valid_o), 64'd1);
    chk({v.nm, "_res"}, 64'(Result_o), 64'(v.r));
    chk({v.nm, "_cout"}, 64'(cout_o), 64'(v.co));
    @(posedge clk);
    #1;
  endtask

  // mode 0: stall window after first output; mode 1: ready toggles
  task automatic run_stream(input int mode, input int budget);
    int          n;
    int          got;
    int          k;
    int          nacc;
    logic        pv;
    logic        pr;
    logic [48:0] pres;
    logic        pc;
    logic        acc;
    logic [49:0] e;
    n    = src_s.size();
    got  = 0;
    k    = 0;
    nacc = 0;
    pv   = 1'b0;
    pr   = 1'b1;
    pres = '0;
    pc   = 1'b0;
    expq.delete();
    while (got < n && k < budget) begin
      if (mode == 0) ready_i = !(k >= 2 && k <= 4);
      else           ready_i = k[0];
      valid_i = (src_s.size() != 0);
      Sum_i   = valid_i ? src_s[0] : '0;
      Carry_i = valid_i ? src_c[0] : '0;
      @(negedge clk);
      acc = valid_i && ready_o;
      if (mode == 0 && k == 2) begin
        chk("fill_ready_low", 64'(ready_o), 64'd0);
        chk("fill_accepts", 64'(nacc), 64'd2);
      end
      if (valid_o) begin
        if (pv && !pr) begin
          chk("hold_res", 64'(Result_o), 64'(pres));
          chk("hold_cout", 64'(cout_o), 64'(pc));
        end
        if (ready_i) begin
          if (expq.size() == 0) begin
            chk("spurious_out", 64'(valid_o), 64'd0);
          end else begin
            e = expq.pop_front();
            chk("stream_res", 64'(Result_o), 64'(e[48:0]));
            chk("stream_cout", 64'(cout_o), 64'(e[49]));
            got++;
          end
        end
      end
      pv   = valid_o;
      pr   = ready_i;
      pres = Result_o;
      pc   = cout_o;
      if (acc) begin
        expq.push_back(model(src_s[0], src_c[0]));
        void'(src_s.pop_front());
        void'(src_c.pop_front());
        nacc++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    chk("stream_count", 64'(got), 64'(n));
    valid_i = 1'b0;
    ready_i = 1'b1;
    Sum_i   = '0;
    Carry_i = '0;
  endtask

  initial begin
    logic [63:0] r64;
    tests = 0;
    fails = 0;

    tbl[0] = '{49'h5, 49'h3, 49'hB, 1'b0, "basic"};
    tbl[1] = '{49'h1FF_FFFF, 49'h0, 49'h1FF_FFFF, 1'b0, "lo_full"};
    tbl[2] = '{49'h1FF_FFFF, 49'h1, 49'h200_0001, 1'b0, "slice_carry"};
    tbl[3] = '{49'h1_FFFF_FFFF_FFFF, 49'h1, 49'h1, 1'b1, "overflow"};
    tbl[4] = '{49'h0, 49'h1_0000_0000_0000, 49'h0, 1'b0, "c_top_drop"};
    tbl[5] = '{49'h0, 49'h1FF_FFFF, 49'h3FF_FFFE, 1'b0, "c_shift"};
    tbl[6] = '{49'h1_0000_0000_0000, 49'h8000_0000_0000,
               49'h0, 1'b1, "top_carry"};
    tbl[7] = '{49'h100_0000, 49'h80_0000, 49'h200_0000, 1'b0,
               "cvec_cross"};
    tbl[8] = '{49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF,
               49'h1_FFFF_FFFF_FFFD, 1'b1, "all_ones"};

    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    Sum_i   = '0;
    Carry_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_res", 64'(Result_o), 64'd0);
    chk("rst_cout", 64'(cout_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) single(tbl[i]);

    for (int i = 1; i <= 4; i++) begin
      src_s.push_back(49'(i));
      src_c.push_back('0);
    end
    run_stream(0, 40);

    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom, $urandom};
      src_s.push_back(r64[48:0]);
      r64 = {$urandom, $urandom};
      src_c.push_back(r64[48:0]);
    end
    run_stream(1, 5000);

    // Fill both stages under stall, then reset with valid_i held high.
    ready_i = 1'b0;
    valid_i = 1'b1;
    Sum_i   = 49'h7;
    Carry_i = '0;
    @(posedge clk);
    #1;
    Sum_i = 49'h8;
    @(posedge clk);
    #1;
    Sum_i = 49'h9;
    @(negedge clk);
    chk("full_ready_low", 64'(ready_o), 64'd0);
    chk("full_valid", 64'(valid_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_res", 64'(Result_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", 64'(ready_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_no_ghost", 64'(valid_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csa_resolve_pipe.md
CSA_RESOLVE_PIPE -- requirements
Module: csa_resolve_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 49, the operand and result width in bits.
REQ-002 SHALL have parameter LO_W, default 25, the width of the low adder slice; legal range 1 <= LO_W < XLEN.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1, upstream asserts that Sum_i/Carry_i hold a valid operand pair.
REQ-006 SHALL have port ready_o, output, 1, block can accept an operand pair this cycle.
REQ-007 SHALL have port Sum_i, input, XLEN, the 4:2 compressor sum vector (weight 1).
REQ-008 SHALL have port Carry_i, input, XLEN, the 4:2 compressor carry vector; bit k carries weight 2^(k+1).
REQ-009 SHALL have port valid_o, output, 1, Result_o holds a valid resolved value.
REQ-010 SHALL have port ready_i, input, 1, downstream accepts Result_o this cycle.
REQ-011 SHALL have port Result_o, output, XLEN, the resolved binary value.
REQ-012 SHALL have port cout_o, output, 1, carry out of bit XLEN-1 of the addition, qualified by valid_o.

Function
REQ-013 SHALL compute the full value F = Sum_i + (Carry_i << 1), evaluated with Carry_i bit XLEN-1 shifted out and discarded.
REQ-014 SHALL drive Result_o = F mod 2^XLEN and cout_o = bit XLEN of F.
REQ-015 SHALL use a two-stage pipeline: stage S1 adds the low LO_W bits and registers the low result, the slice carry, and the high operand bits; stage S2 adds the high XLEN-LO_W bits plus the registered carry.
REQ-016 SHALL have a latency of exactly 2 cycles from the input handshake (valid_i and ready_o) to valid_o, with no stall.
REQ-017 SHALL sustain a throughput of one operand pair per cycle while ready_i stays high.
REQ-018 SHALL track occupancy with per-stage valid bits s1_v and s2_v; S2 drives the outputs directly, so valid_o = s2_v.
REQ-019 SHALL advance S2 when s2_v is 0 or ready_i is 1; S1 moves into S2 only when S2 advances.
REQ-020 SHALL drive ready_o = !s1_v || (S2 advances), combinationally; ready_o SHALL NOT depend on valid_i.
REQ-021 SHALL hold Result_o and cout_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL, on simultaneous S2 drain and S1 refill in the same cycle, lose and duplicate no item and keep order strictly FIFO.
REQ-023 SHALL ignore valid_i when ready_o=0; the upstream holds its data.
REQ-024 SHALL hold no more than 2 items and SHALL drop no accepted item.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, clear s1_v and s2_v to 0, giving valid_o=0, Result_o=0 and cout_o=0 on the next cycle.
REQ-026 SHALL drive ready_o=1 in the cycle after reset deasserts.
REQ-027 SHALL, when reset is asserted mid-operation, discard all in-flight items; no discarded item appears on the output after reset.
REQ-028 SHALL NOT accept any input handshake in a cycle where rst=1.

Verification
REQ-029 SHALL cover this scenario: XLEN=49, LO_W=25, Sum_i=0x0000_0000_0005, Carry_i=0x3, ready_i=1 -> valid_o=1 two cycles later with Result_o=0xB and cout_o=0.
REQ-030 SHALL cover this scenario: carry across the slice boundary, Sum_i=2^25-1 (0x1FF_FFFF), Carry_i=0 then Sum_i=0x1FF_FFFF with Carry_i=0x1 -> Result_o=0x1FF_FFFF, then 0x200_0001.
REQ-031 SHALL cover this scenario: overflow, Sum_i=2^49-1, Carry_i=0x1 -> Result_o=0x1, cout_o=1; Carry_i bit 48 set with Sum_i=0 -> Result_o=0, cout_o=0.
REQ-032 SHALL cover this scenario: back-to-back inputs 1,2,3,4 (Carry_i=0) with ready_i held 0 for 3 cycles after the first output -> ready_o falls to 0 after 2 accepts, and outputs 1,2,3,4 appear in order with no loss.
REQ-033 SHALL cover this scenario: streaming with ready_i toggling every cycle and valid_i always 1 -> each output stays stable while stalled, and order and count match a reference model over 1000 random pairs.
REQ-034 SHALL cover this scenario: rst pulsed while both stages are full -> valid_o=0 the next cycle, ready_o=1 after deassert, and no pre-reset item is emitted.
